// File: rtl/ltc5548_sys_capture_master.sv
// ltc5548_sys_capture_master
//   Avalon-MM write master that moves a stream of sample words into a word-addressed
//   on-chip memory. Words are taken from a valid/ready sink into a small FIFO and
//   written to consecutive word addresses starting at a programmable base address.
//   Address arithmetic wraps modulo 2^ADDR_W.
//
// Ports
//   clk, reset       system clock, synchronous active-high reset
//   start, abort     one-cycle control pulses; base_addr/length are sampled on start
//   busy, done       capture in progress / one-cycle completion pulse
//   snk_*            sample stream sink (transfer = snk_valid & snk_ready)
//   avm_*            Avalon-MM write master port
//   checksum         modulo-2^DATA_W sum of the words written in the current capture
//
// Build option
//   LTC5548_CAPTURE_CHECKSUM_EN  when defined, builds the checksum accumulator;
//                                otherwise checksum is tied to zero.
module ltc5548_sys_capture_master #(
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  input  logic [DATA_W-1:0] snk_data,
  input  logic              snk_valid,
  output logic              snk_ready,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  output logic [DATA_W-1:0] checksum
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  // S_DRAIN: abort seen while a write was stalled; wait for it to be accepted.
  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] next_addr_q;
  logic [ADDR_W-1:0] acc_cnt_q;
  logic [ADDR_W-1:0] wr_cnt_q;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W:0]    level_q;

  logic start_ok;
  logic wr_accept;
  logic bus_free;
  logic last_write;
  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic done_d;

  assign start_ok   = (state_q == S_IDLE) & start & ~abort;
  assign wr_accept  = avm_write & ~avm_waitrequest;
  assign bus_free   = ~avm_write | ~avm_waitrequest;
  assign last_write = (wr_cnt_q == len_q - ADDR_W'(1));
  assign fifo_full  = (level_q == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);

  assign busy           = (state_q != S_IDLE);
  assign snk_ready      = (state_q == S_RUN) & ~fifo_full & (acc_cnt_q < len_q);
  assign push           = snk_valid & snk_ready;
  // An abort pulse blocks the next pop so that only an already-issued write finishes.
  assign pop            = (state_q == S_RUN) & ~abort & ~fifo_empty & bus_free;
  assign avm_byteenable = 4'hF;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_RUN;
          done_d  = (length == '0);
        end
      end
      S_RUN: begin
        if (len_q == '0) begin
          state_d = S_IDLE;
        end else if (wr_accept && last_write) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (abort) begin
          state_d = bus_free ? S_IDLE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (bus_free) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done          <= 1'b0;
      len_q         <= '0;
      next_addr_q   <= '0;
      acc_cnt_q     <= '0;
      wr_cnt_q      <= '0;
      avm_write     <= 1'b0;
      avm_address   <= '0;
      avm_writedata <= '0;
    end else begin
      done <= done_d;
      if (start_ok) begin
        len_q       <= length;
        next_addr_q <= base_addr;
        acc_cnt_q   <= '0;
        wr_cnt_q    <= '0;
      end else begin
        if (push)      acc_cnt_q   <= acc_cnt_q + ADDR_W'(1);
        if (wr_accept) wr_cnt_q    <= wr_cnt_q + ADDR_W'(1);
        if (pop)       next_addr_q <= next_addr_q + ADDR_W'(1);
      end
      if (pop) begin
        avm_write     <= 1'b1;
        avm_address   <= next_addr_q;
        avm_writedata <= fifo_mem[rd_ptr_q];
      end else if (wr_accept) begin
        avm_write <= 1'b0;
      end
    end
  end

  // FIFO is held empty whenever the FSM is idle, which also flushes it after an abort.
  always_ff @(posedge clk) begin
    if (reset || state_q == S_IDLE) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   level_q <= level_q + (PTR_W+1)'(1);
        2'b01:   level_q <= level_q - (PTR_W+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= snk_data;
  end

`ifdef LTC5548_CAPTURE_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset || start_ok) checksum <= '0;
    else if (wr_accept)    checksum <= checksum + avm_writedata;
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_ltc5548_sys_capture_master.sv
module tb_ltc5548_sys_capture_master;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] length = '0;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] snk_data = '0;
  logic              snk_valid = 1'b0;
  logic              snk_ready;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_write;
  logic [DATA_W-1:0] avm_writedata;
  logic [3:0]        avm_byteenable;
  logic              avm_waitrequest = 1'b0;
  logic [DATA_W-1:0] checksum;

  ltc5548_sys_capture_master #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .base_addr(base_addr),
    .length(length),
    .busy(busy),
    .done(done),
    .snk_data(snk_data),
    .snk_valid(snk_valid),
    .snk_ready(snk_ready),
    .avm_address(avm_address),
    .avm_write(avm_write),
    .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n++;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  // Reference model: a capture is a list of accepted samples that must appear on the
  // bus in order at base+k; completion/abort rules decide when busy and done change.
  logic [DATA_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] log_addr[$];
  logic [DATA_W-1:0] log_data[$];
  int                log_cyc[$];
  bit                m_busy = 0, m_aborting = 0, m_zero = 0, m_done_exp = 0;
  bit                armed = 0, prev_reset = 0, p_stall = 0;
  logic [ADDR_W-1:0] m_base = '0, m_len = '0, p_addr = '0;
  logic [DATA_W-1:0] m_cs = '0, p_data = '0;
  int unsigned       m_acc = 0, m_wr = 0;
  int                done_cyc = -1, n_done = 0, stall_drop = 0;
  bit                t3_mon = 0;

  always @(negedge clk) begin : compare
    bit busy_before;
    bit done_next;
    bit allowed;
    logic [DATA_W-1:0] cs_expect;
    logic [ADDR_W-1:0] ea;
`ifdef LTC5548_CAPTURE_CHECKSUM_EN
    cs_expect = m_cs;
`else
    cs_expect = '0;
`endif
    if (armed) begin
      check("busy", busy, m_busy);
      check("done", done, m_done_exp);
      check("checksum", checksum, cs_expect);
      if (!m_busy) check("idle_no_write", avm_write, 0);
      if (avm_write) check("byteenable", avm_byteenable, 4'hF);
      if (p_stall) begin
        check("stall_write_held", avm_write, 1);
        check("stall_addr_held", avm_address, p_addr);
        check("stall_data_held", avm_writedata, p_data);
      end
      if (prev_reset) begin
        check("rst_address", avm_address, 0);
        check("rst_writedata", avm_writedata, 0);
        check("rst_ready", snk_ready, 0);
      end
    end
    armed = 1;
    if (done) begin
      done_cyc = cyc_n;
      n_done++;
    end
    busy_before = m_busy;
    done_next = 0;
    if (reset) begin
      m_busy = 0; m_aborting = 0; m_zero = 0; m_cs = '0;
      m_acc = 0; m_wr = 0;
      exp_q.delete();
      p_stall = 0;
      prev_reset = 1;
    end else begin
      prev_reset = 0;
      if (m_zero) begin
        m_busy = 0;
        m_zero = 0;
      end
      allowed = busy_before && !m_aborting && (m_acc < m_len);
      check("ready_legal", snk_ready && !allowed, 0);
      if (t3_mon && snk_valid && !snk_ready && busy_before && (m_acc < m_len)) stall_drop++;
      if (snk_valid && snk_ready) begin
        exp_q.push_back(snk_data);
        m_acc++;
      end
      if (avm_write && !avm_waitrequest) begin
        ea = m_base + ADDR_W'(m_wr);
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          check("write_addr", avm_address, ea);
          check("write_data", avm_writedata, exp_q.pop_front());
        end
        log_addr.push_back(avm_address);
        log_data.push_back(avm_writedata);
        log_cyc.push_back(cyc_n);
        m_cs = m_cs + avm_writedata;
        m_wr++;
        if (!m_aborting && m_busy && m_wr == m_len) begin
          m_busy = 0;
          done_next = 1;
        end
      end
      if (busy_before && m_busy && abort && !m_aborting) m_aborting = 1;
      if (m_aborting && (!avm_write || !avm_waitrequest)) begin
        m_busy = 0;
        m_aborting = 0;
        exp_q.delete();
      end
      if (!busy_before && start && !abort) begin
        m_busy = 1; m_base = base_addr; m_len = length;
        m_acc = 0; m_wr = 0; m_cs = '0;
        exp_q.delete();
        if (length == '0) begin
          done_next = 1;
          m_zero = 1;
        end
      end
      p_stall = avm_write && avm_waitrequest;
      p_addr  = avm_address;
      p_data  = avm_writedata;
    end
    m_done_exp = done_next;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] l);
    base_addr = b;
    length = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input int n, input logic [31:0] first, input logic [31:0] step);
    int i = 0;
    int guard = 0;
    bit took;
    while (i < n && guard < 200) begin
      snk_valid = 1'b1;
      snk_data = first + step * i;
      @(negedge clk);
      took = snk_ready;
      tick();
      if (took) i++;
      guard++;
    end
    snk_valid = 1'b0;
    check("feed_accepted", i, n);
  endtask

  task automatic wait_done(input string nm, input int budget);
    int k = 0;
    bit seen = 0;
    while (k < budget && !seen) begin
      @(negedge clk);
      seen = done;
      k++;
    end
    check(nm, seen, 1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0;
    int d0;
    logic [31:0] cs_lit;
    repeat (3) tick();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_write", avm_write, 0);
    check("reset_checksum", checksum, 0);
    reset = 1'b0;
    tick();

    // 1: three words, consecutive writes, done one cycle after the last
    l0 = log_addr.size();
    do_start(15'h0010, 15'd3);
    check("t1_busy_after_start", busy, 1);
    feed(3, 32'hA5A5_0001, 32'h1);
    wait_done("t1_done_seen", 20);
    check("t1_nwrites", log_addr.size() - l0, 3);
    check("t1_addr0", log_addr[l0], 15'h0010);
    check("t1_addr1", log_addr[l0+1], 15'h0011);
    check("t1_addr2", log_addr[l0+2], 15'h0012);
    check("t1_data0", log_data[l0], 32'hA5A5_0001);
    check("t1_data1", log_data[l0+1], 32'hA5A5_0002);
    check("t1_data2", log_data[l0+2], 32'hA5A5_0003);
    check("t1_consec01", log_cyc[l0+1] - log_cyc[l0], 1);
    check("t1_consec12", log_cyc[l0+2] - log_cyc[l0+1], 1);
    check("t1_done_latency", done_cyc - log_cyc[l0+2], 1);

    // 2: address wrap
    l0 = log_addr.size();
    do_start(15'h7FFE, 15'd4);
    feed(4, 32'h8000_0001, 32'h1000_0001);
    wait_done("t2_done_seen", 20);
    check("t2_addr0", log_addr[l0], 15'h7FFE);
    check("t2_addr1", log_addr[l0+1], 15'h7FFF);
    check("t2_addr2", log_addr[l0+2], 15'h0000);
    check("t2_addr3", log_addr[l0+3], 15'h0001);
`ifdef LTC5548_CAPTURE_CHECKSUM_EN
    cs_lit = 32'h6000_000A;
`else
    cs_lit = 32'h0;
`endif
    check("t2_checksum", checksum, cs_lit);
    tick();
    check("t2_checksum_hold", checksum, cs_lit);

    // 3: stall on the second write fills the FIFO
    l0 = log_addr.size();
    t3_mon = 1;
    do_start(15'h0100, 15'd8);
    fork
      feed(8, 32'h3000_0000, 32'h11);
      begin
        int k = 0;
        bit seen = 0;
        while (k < 50 && !seen) begin
          @(negedge clk);
          seen = avm_write && !avm_waitrequest;
          k++;
        end
        check("t3_first_write_seen", seen, 1);
        tick();
        avm_waitrequest = 1'b1;
        repeat (3) tick();
        avm_waitrequest = 1'b0;
      end
    join
    wait_done("t3_done_seen", 40);
    t3_mon = 0;
    check("t3_ready_dropped", stall_drop > 0, 1);
    check("t3_nwrites", log_addr.size() - l0, 8);
    for (int i = 0; i < 8; i++) begin
      check("t3_addr", log_addr[l0+i], 15'h0100 + 15'(i));
      check("t3_data", log_data[l0+i], 32'h3000_0000 + 32'h11 * i);
    end

    // 4: zero length, second start while busy ignored
    l0 = log_addr.size();
    base_addr = 15'h0040;
    length = 15'd0;
    start = 1'b1;
    tick();
    length = 15'd5;
    check("t4_busy_n1", busy, 1);
    check("t4_done_n1", done, 1);
    tick();
    start = 1'b0;
    check("t4_busy_n2", busy, 0);
    check("t4_done_n2", done, 0);
    repeat (3) tick();
    check("t4_busy_idle", busy, 0);
    check("t4_nwrites", log_addr.size() - l0, 0);

    // start and abort together in idle: abort wins
    base_addr = 15'h0020;
    length = 15'd2;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("sa_busy", busy, 0);
    tick();
    check("sa_busy2", busy, 0);

    // 5: abort after 2 of 8 words
    l0 = log_addr.size();
    d0 = n_done;
    do_start(15'h0200, 15'd8);
    feed(2, 32'h5000_0000, 32'h1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (3) tick();
    check("t5_busy", busy, 0);
    check("t5_no_done", n_done - d0, 0);
    check("t5_writes_le2", (log_addr.size() - l0) <= 2, 1);

    // 5b: abort while a write is stalled; the pending write must complete
    l0 = log_addr.size();
    do_start(15'h0400, 15'd8);
    feed(3, 32'h6000_0000, 32'h1);
    avm_waitrequest = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5b_busy_drain", busy, 1);
    tick();
    avm_waitrequest = 1'b0;
    repeat (3) tick();
    check("t5b_busy", busy, 0);
    check("t5b_no_done", n_done - d0, 0);
    check("t5b_nwrites", log_addr.size() - l0, 2);
    check("t5b_last_data", log_data[log_data.size()-1], 32'h6000_0001);

    // clean capture after abort
    l0 = log_addr.size();
    do_start(15'h0300, 15'd3);
    feed(3, 32'h7700_0000, 32'h10);
    wait_done("t5c_done_seen", 20);
    check("t5c_nwrites", log_addr.size() - l0, 3);
    check("t5c_addr0", log_addr[l0], 15'h0300);
    check("t5c_data2", log_data[l0+2], 32'h7700_0020);

    // 6: reset mid-capture
    do_start(15'h0500, 15'd8);
    feed(3, 32'h9000_0000, 32'h1);
    snk_valid = 1'b1;
    reset = 1'b1;
    tick();
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_write", avm_write, 0);
    check("t6_addr", avm_address, 0);
    check("t6_wdata", avm_writedata, 0);
    check("t6_checksum", checksum, 0);
    check("t6_ready", snk_ready, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_ready_hold", snk_ready, 0);
    end
    snk_valid = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
